// File: rtl/risk_def.sv
// Shared types and constants for the pre-trade risk gate.
package risk_def;

    localparam int unsigned REJ_W     = 4;
    localparam int unsigned RSP_ID_W  = 16;
    localparam int unsigned RSP_ACC_W = 64;

    typedef enum logic {
        ACTIVE = 1'b0,
        LOCKED = 1'b1
    } client_state_e;

    // Decision payload at its widest; narrower configurations zero-extend into it.
    typedef struct packed {
        logic                 accept;
        logic                 locked;
        logic [RSP_ID_W-1:0]  id;
        logic [RSP_ACC_W-1:0] exposure;
    } risk_rsp_t;

endpackage

// File: rtl/risk_client_table.sv
// Per-client limit/exposure/lockout table with a combinational read port.
// Exchange releases apply before the order commit; config writes override lockout.
module risk_client_table
    import risk_def::*;
#(
    parameter int unsigned N_CLIENTS = 32,
    parameter int unsigned ID_W      = $clog2(N_CLIENTS),
    parameter int unsigned AMT_W     = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned REJ_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic [ID_W-1:0]  ex_id_i,
    input  logic [AMT_W-1:0] ex_amount_i,
    input  logic             cfg_we_i,
    input  logic [ID_W-1:0]  cfg_id_i,
    input  logic [ACC_W-1:0] cfg_max_i,
    input  logic [ID_W-1:0]  rd_id_i,
    input  logic             ord_we_i,
    input  logic             ord_accept_i,
    input  logic [ACC_W-1:0] ord_exposure_i,
    output logic [ACC_W-1:0] rd_max_c_o,
    output logic [ACC_W-1:0] rd_exposure_c_o,
    output client_state_e    rd_state_c_o,
    output logic             ex_underflow_c_o
);

    localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [ACC_W-1:0] max_q [N_CLIENTS];
    logic [ACC_W-1:0] max_d [N_CLIENTS];
    logic [ACC_W-1:0] exp_q [N_CLIENTS];
    logic [ACC_W-1:0] exp_d [N_CLIENTS];
    logic [ACC_W-1:0] exp_ev[N_CLIENTS];
    logic [REJ_W-1:0] rej_q [N_CLIENTS];
    logic [REJ_W-1:0] rej_d [N_CLIENTS];
    client_state_e    st_q  [N_CLIENTS];
    client_state_e    st_d  [N_CLIENTS];
    logic [IDX_W-1:0] rd_idx;

    // Exposure after this cycle's exchange release, clamped at zero.
    always_comb begin : event_apply
        ex_underflow_c_o = 1'b0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            exp_ev[i] = exp_q[i];
            if (ex_valid_i && (32'(ex_id_i) == i)) begin
                if (ACC_W'(ex_amount_i) > exp_q[i]) begin
                    exp_ev[i]        = '0;
                    ex_underflow_c_o = 1'b1;
                end else begin
                    exp_ev[i] = exp_q[i] - ACC_W'(ex_amount_i);
                end
            end
        end
    end

    always_comb begin : read_port
        rd_idx          = (32'(rd_id_i) < N_CLIENTS) ? IDX_W'(rd_id_i) : '0;
        rd_max_c_o      = max_q[rd_idx];
        rd_exposure_c_o = exp_ev[rd_idx];
        rd_state_c_o    = st_q[rd_idx];
    end

    always_comb begin : table_next
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            max_d[i] = max_q[i];
            exp_d[i] = exp_ev[i];
            rej_d[i] = rej_q[i];
            st_d[i]  = st_q[i];
            if (ord_we_i && (32'(rd_id_i) == i)) begin
                if (ord_accept_i) begin
                    exp_d[i] = ord_exposure_i;
                    rej_d[i] = '0;
                end else if (st_q[i] == ACTIVE) begin
                    rej_d[i] = rej_q[i] + REJ_W'(1);
                    if (rej_d[i] >= REJ_W'(REJ_LIMIT)) begin
                        st_d[i] = LOCKED;
                    end
                end
            end
            if (cfg_we_i && (32'(cfg_id_i) == i)) begin
                max_d[i] = cfg_max_i;
                rej_d[i] = '0;
                st_d[i]  = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : table_regs
        if (rst) begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                max_q[i] <= '0;
                exp_q[i] <= '0;
                rej_q[i] <= '0;
                st_q[i]  <= ACTIVE;
            end
        end else begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                max_q[i] <= max_d[i];
                exp_q[i] <= exp_d[i];
                rej_q[i] <= rej_d[i];
                st_q[i]  <= st_d[i];
            end
        end
    end

endmodule

// File: rtl/risk_gate_array.sv
// Pre-trade risk gate: per-client limit check with registered accept/reject
// decisions, valid/ready flow control, exposure release and reject lockout.
module risk_gate_array
    import risk_def::*;
#(
    parameter int unsigned N_CLIENTS = 32,
    parameter int unsigned ID_W      = $clog2(N_CLIENTS),
    parameter int unsigned AMT_W     = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned REJ_LIMIT = 3
) (
    input  logic             clk,
    input  logic             HRESETn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    input  logic [AMT_W-1:0] req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_accept,
    output logic             rsp_locked,
    output logic [ID_W-1:0]  rsp_id,
    output logic [ACC_W-1:0] rsp_exposure,
    input  logic             ex_valid,
    input  logic [ID_W-1:0]  ex_id,
    input  logic [AMT_W-1:0] ex_amount,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_id,
    input  logic [ACC_W-1:0] cfg_max,
    output logic             underflow
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] tbl_max;
    logic [ACC_W-1:0] tbl_exp;
    client_state_e    tbl_state;
    logic             ex_underflow;
    logic             fire;
    logic             id_ok;
    logic [SUM_W-1:0] sum;
    logic             dec_accept;
    logic             dec_locked;
    logic [ACC_W-1:0] dec_exp;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_accept_q, rsp_accept_d;
    logic             rsp_locked_q, rsp_locked_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ACC_W-1:0] rsp_exp_q, rsp_exp_d;
    logic             underflow_q, underflow_d;

    risk_client_table #(
        .N_CLIENTS (N_CLIENTS),
        .ID_W      (ID_W),
        .AMT_W     (AMT_W),
        .ACC_W     (ACC_W),
        .REJ_LIMIT (REJ_LIMIT)
    ) u_table (
        .clk              (clk),
        .rst              (HRESETn),
        .ex_valid_i       (ex_valid),
        .ex_id_i          (ex_id),
        .ex_amount_i      (ex_amount),
        .cfg_we_i         (cfg_we),
        .cfg_id_i         (cfg_id),
        .cfg_max_i        (cfg_max),
        .rd_id_i          (req_id),
        .ord_we_i         (fire),
        .ord_accept_i     (dec_accept),
        .ord_exposure_i   (dec_exp),
        .rd_max_c_o       (tbl_max),
        .rd_exposure_c_o  (tbl_exp),
        .rd_state_c_o     (tbl_state),
        .ex_underflow_c_o (ex_underflow)
    );

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign fire      = req_valid && req_ready;

    // Limit check on the post-release exposure; one extra bit keeps the sum from wrapping.
    always_comb begin : decide
        id_ok      = (32'(req_id) < N_CLIENTS);
        sum        = {1'b0, tbl_exp} + SUM_W'(req_amount);
        dec_accept = 1'b0;
        dec_locked = 1'b0;
        dec_exp    = '0;
        if (id_ok) begin
            dec_exp = tbl_exp;
            if (tbl_state == LOCKED) begin
                dec_locked = 1'b1;
            end else if (sum <= {1'b0, tbl_max}) begin
                dec_accept = 1'b1;
                dec_exp    = sum[ACC_W-1:0];
            end
        end
    end

    always_comb begin : rsp_next
        rsp_valid_d  = rsp_valid_q;
        rsp_accept_d = rsp_accept_q;
        rsp_locked_d = rsp_locked_q;
        rsp_id_d     = rsp_id_q;
        rsp_exp_d    = rsp_exp_q;
        underflow_d  = underflow_q | ex_underflow;
        if (fire) begin
            rsp_valid_d  = 1'b1;
            rsp_accept_d = dec_accept;
            rsp_locked_d = dec_locked;
            rsp_id_d     = req_id;
            rsp_exp_d    = dec_exp;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge HRESETn) begin : rsp_regs
        if (HRESETn) begin
            rsp_valid_q  <= 1'b0;
            rsp_accept_q <= 1'b0;
            rsp_locked_q <= 1'b0;
            rsp_id_q     <= '0;
            rsp_exp_q    <= '0;
            underflow_q  <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_accept_q <= rsp_accept_d;
            rsp_locked_q <= rsp_locked_d;
            rsp_id_q     <= rsp_id_d;
            rsp_exp_q    <= rsp_exp_d;
            underflow_q  <= underflow_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_accept   = rsp_accept_q;
    assign rsp_locked   = rsp_locked_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_exposure = rsp_exp_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_risk_gate_array.sv
// Scoreboard bench for risk_gate_array: directed scenarios plus random traffic
// against a per-client arithmetic model of limits, exposure and lockout.
module tb_risk_gate_array;
    import risk_def::*;

    localparam int unsigned N   = 32;
    localparam int unsigned IDW = 6;
    localparam int unsigned AW  = 16;
    localparam int unsigned CW  = 20;
    localparam int unsigned RL  = 3;
    localparam longint unsigned CMAX = (64'd1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready;
    logic [IDW-1:0] req_id;
    logic [AW-1:0]  req_amount;
    logic           rsp_valid, rsp_ready, rsp_accept, rsp_locked;
    logic [IDW-1:0] rsp_id;
    logic [CW-1:0]  rsp_exposure;
    logic           ex_valid;
    logic [IDW-1:0] ex_id;
    logic [AW-1:0]  ex_amount;
    logic           cfg_we;
    logic [IDW-1:0] cfg_id;
    logic [CW-1:0]  cfg_max;
    logic           underflow;

    always #5 clk = ~clk;

    risk_gate_array #(
        .N_CLIENTS (N),
        .ID_W      (IDW),
        .AMT_W     (AW),
        .ACC_W     (CW),
        .REJ_LIMIT (RL)
    ) dut (
        .clk          (clk),
        .HRESETn      (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_id       (req_id),
        .req_amount   (req_amount),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_accept   (rsp_accept),
        .rsp_locked   (rsp_locked),
        .rsp_id       (rsp_id),
        .rsp_exposure (rsp_exposure),
        .ex_valid     (ex_valid),
        .ex_id        (ex_id),
        .ex_amount    (ex_amount),
        .cfg_we       (cfg_we),
        .cfg_id       (cfg_id),
        .cfg_max      (cfg_max),
        .underflow    (underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    risk_rsp_t       sb[$];
    longint unsigned m_max[N];
    longint unsigned m_exp[N];
    int              m_rej[N];
    bit              m_lock[N];
    bit              m_under;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_max[i]  = 0;
            m_exp[i]  = 0;
            m_rej[i]  = 0;
            m_lock[i] = 1'b0;
        end
        m_under = 1'b0;
        sb.delete();
    endtask

    // Apply one clock of stimulus: event first, then order against old max, then config.
    task automatic tick();
        bit        ready, fire, und;
        int        id;
        risk_rsp_t r;
        #1;
        ready = (sb.size() == 0) || rsp_ready;
        chk("req_ready", longint'(req_ready), longint'(ready));
        fire = req_valid && ready;
        und  = m_under;
        r    = '0;
        if (ex_valid && int'(ex_id) < N) begin
            id = int'(ex_id);
            if (longint'(ex_amount) > m_exp[id]) begin
                und       = 1'b1;
                m_exp[id] = 0;
            end else begin
                m_exp[id] = m_exp[id] - longint'(ex_amount);
            end
        end
        if (fire) begin
            r.id = RSP_ID_W'(req_id);
            id   = int'(req_id);
            if (id < N) begin
                if (m_lock[id]) begin
                    r.locked = 1'b1;
                end else if (m_exp[id] + longint'(req_amount) <= m_max[id]) begin
                    r.accept  = 1'b1;
                    m_exp[id] = m_exp[id] + longint'(req_amount);
                    m_rej[id] = 0;
                end else begin
                    m_rej[id]++;
                    if (m_rej[id] == int'(RL)) m_lock[id] = 1'b1;
                end
                r.exposure = m_exp[id];
            end
        end
        if (cfg_we && int'(cfg_id) < N) begin
            id         = int'(cfg_id);
            m_max[id]  = longint'(cfg_max);
            m_lock[id] = 1'b0;
            m_rej[id]  = 0;
        end
        @(posedge clk);
        if (fire) sb.push_back(r);
        m_under = und;
        #1;
    endtask

    task automatic set_idle();
        req_valid = 1'b0; req_id = '0; req_amount = '0;
        ex_valid  = 1'b0; ex_id  = '0; ex_amount  = '0;
        cfg_we    = 1'b0; cfg_id = '0; cfg_max    = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic order(input int id, input int amt);
        req_valid = 1'b1; req_id = IDW'(id); req_amount = AW'(amt);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic cfg(input int id, input longint unsigned mx);
        cfg_we = 1'b1; cfg_id = IDW'(id); cfg_max = CW'(mx);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic exev(input int id, input int amt);
        ex_valid = 1'b1; ex_id = IDW'(id); ex_amount = AW'(amt);
        tick();
        ex_valid = 1'b0;
    endtask

    // Monitor: every presented decision is compared to the scoreboard head.
    always @(negedge clk) begin
        risk_rsp_t e;
        if (!rst) begin
            chk("rsp_valid", longint'(rsp_valid), longint'(sb.size() != 0));
            chk("underflow", longint'(underflow), longint'(m_under));
            if (rsp_valid && sb.size() != 0) begin
                e = sb[0];
                chk("rsp_accept",   longint'(rsp_accept),   longint'(e.accept));
                chk("rsp_locked",   longint'(rsp_locked),   longint'(e.locked));
                chk("rsp_id",       longint'(rsp_id),       longint'(e.id));
                chk("rsp_exposure", longint'(rsp_exposure), e.exposure);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid",    longint'(rsp_valid),    0);
        chk("reset_rsp_accept",   longint'(rsp_accept),   0);
        chk("reset_rsp_locked",   longint'(rsp_locked),   0);
        chk("reset_rsp_id",       longint'(rsp_id),       0);
        chk("reset_rsp_exposure", longint'(rsp_exposure), 0);
        chk("reset_underflow",    longint'(underflow),    0);
        rst = 1'b0;

        // Basic accept up to the limit, then reject.
        cfg(3, 100);
        order(3, 60);
        order(3, 40);
        order(3, 1);

        // Lockout after repeated rejects; config unlocks.
        cfg(5, 10);
        repeat (3) order(5, 20);
        order(5, 1);
        cfg(5, 10);
        order(5, 1);

        // Underflow clamp and same-cycle release + order.
        cfg(2, 50);
        order(2, 50);
        exev(2, 80);
        order(2, 50);
        ex_valid = 1'b1; ex_id = IDW'(2); ex_amount = AW'(30);
        req_valid = 1'b1; req_id = IDW'(2); req_amount = AW'(30);
        tick();
        set_idle();

        // Config and lock transition in the same cycle: config wins.
        cfg(6, 5);
        repeat (2) order(6, 9);
        cfg_we = 1'b1; cfg_id = IDW'(6); cfg_max = CW'(20);
        req_valid = 1'b1; req_id = IDW'(6); req_amount = AW'(9);
        tick();
        set_idle();
        order(6, 9);

        // Back-pressure with a release applied during the stall.
        cfg(3, 1000);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_id = IDW'(3);
        for (int k = 0; k < 5; k++) begin
            req_amount = AW'(k + 7);
            ex_valid   = (k == 2);
            ex_id      = IDW'(3);
            ex_amount  = AW'(10);
            tick();
        end
        ex_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        set_idle();
        tick();

        // Out-of-range ids: rejected or ignored.
        order(40, 5);
        order(63, 0);
        exev(40, 500);
        cfg(33, 1000);
        order(33, 1);

        // Width boundary: sum just above the all-ones limit must not wrap.
        cfg(7, CMAX);
        repeat (16) order(7, 65535);
        order(7, 10);
        order(7, 6);
        order(7, 5);
        order(7, 1);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            req_valid  = ($urandom % 4) != 0;
            req_id     = IDW'($urandom_range(0, 39));
            req_amount = AW'($urandom_range(0, 400));
            rsp_ready  = ($urandom % 4) != 0;
            ex_valid   = ($urandom % 5) == 0;
            ex_id      = IDW'($urandom_range(0, 35));
            ex_amount  = AW'($urandom_range(0, 300));
            cfg_we     = ($urandom % 10) == 0;
            cfg_id     = IDW'($urandom_range(0, 35));
            cfg_max    = CW'($urandom_range(0, 3000));
            tick();
        end
        set_idle();
        repeat (3) tick();

        // Reset while a decision is stalled.
        cfg(3, 500);
        rsp_ready = 1'b0;
        order(3, 20);
        rst = 1'b1;
        model_reset();
        #2;
        chk("midreset_rsp_valid", longint'(rsp_valid), 0);
        @(posedge clk);
        #1;
        chk("midreset_underflow", longint'(underflow), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        order(3, 1);
        order(2, 1);
        order(7, 1);
        order(3, 0);

        set_idle();
        repeat (4) tick();
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risk_gate_array.md
# risk_gate_array

Parametrised pre-trade risk gate for N clients, sitting between the CPU order path and the exchange feed in the shared top level. Holds a per-client table of limit, outstanding exposure and lockout state. Every CPU order gets a registered accept/reject decision; exchange cancel/fill events reduce exposure. Compared with the single-check top level, it adds:

- valid/ready flow control;
- underflow clamping;
- automatic client lockout after repeated rejects.

## Interface
Parameters:
- N_CLIENTS, 32, number of client table entries
- ID_W, $clog2(N_CLIENTS), client id width
- AMT_W, 16, order/event amount width
- ACC_W, 32, exposure and limit width
- REJ_LIMIT, 3, consecutive rejects that lock a client (1..15)

Ports:
- clk  in  1  single clock, all logic on posedge
- HRESETn  in  1  asynchronous, active-high reset (asserted = 1, despite the suffix)
- req_valid  in  1  CPU order request valid
- req_ready  out  1  gate can take a request
- req_id  in  ID_W  client id of order
- req_amount  in  AMT_W  order amount
- rsp_valid  out  1  decision valid
- rsp_ready  in  1  consumer takes decision
- rsp_accept  out  1  1 = order accepted, 0 = rejected
- rsp_locked  out  1  rejection due to lockout
- rsp_id  out  ID_W  client id of decision
- rsp_exposure  out  ACC_W  client exposure after decision
- ex_valid  in  1  exchange cancel/fill event
- ex_id  in  ID_W  client id of event
- ex_amount  in  AMT_W  amount released
- cfg_we  in  1  limit write strobe
- cfg_id  in  ID_W  client to configure
- cfg_max  in  ACC_W  new max-to-trade
- underflow  out  1  sticky: an event exceeded exposure

## Operation
- Per client: `max` (ACC_W), `exposure` (ACC_W), `rej_cnt` (4 bits), `state` ∈ {ACTIVE, LOCKED}.
- Order handshake fires on req_valid && req_ready.
- Check sum = exposure + req_amount, computed at ACC_W+1 bits so it cannot wrap.
- Accept iff state == ACTIVE and sum <= max. On accept:
  - exposure <= sum[ACC_W-1:0];
  - rej_cnt <= 0.
- Reject (ACTIVE, sum > max):
  - exposure unchanged;
  - rej_cnt++;
  - at REJ_LIMIT, state -> LOCKED and rej_cnt holds.
- LOCKED: every order is rejected with rsp_locked = 1; rej_cnt unchanged.
- Exchange event: exposure <= exposure - ex_amount, clamped at 0.
  - If ex_amount > exposure, underflow is set; it clears only on reset.
- Config write: max <= cfg_max, state -> ACTIVE, rej_cnt <= 0.
- Same-cycle ordering when ids match:
  - ex event is applied first; the order check sees the post-event exposure.
  - The order check uses the pre-cycle max.
  - Config write wins over a lock transition in the same cycle, so the client ends ACTIVE.
- Ids >= N_CLIENTS:
  - order: rejected, rsp_locked = 0, no table change;
  - event or config: ignored.
- Reset: all max = 0 (every order rejected until configured), exposure = 0, rej_cnt = 0, state ACTIVE, rsp_valid = 0, rsp_accept = 0, rsp_locked = 0, rsp_id = 0, rsp_exposure = 0, underflow = 0.

## Timing
- The decision is registered. rsp_* are valid the cycle after the handshake, i.e. 1-cycle latency.
- req_ready = !rsp_valid || rsp_ready. The single output register gives full throughput, one order per cycle.
- rsp_* hold stable while rsp_valid && !rsp_ready.
- Table updates commit on the handshake clock edge.
- Back-to-back orders to the same client check against the updated exposure; no hazard, since the table is flops.
- ex_valid and cfg_we are never back-pressured and apply on every cycle they are high, including while the response is stalled.
- Reset mid-stall drops the pending response; rsp_valid = 0 the cycle after reset asserts.

## Structure
- Package `risk_def`:
  - `client_state_e` {ACTIVE, LOCKED};
  - `risk_rsp_t` struct {accept, locked, id, exposure};
  - REJ counter width constant.
- Sub-module `risk_client_table`:
  - per-client flop arrays;
  - combinational read port;
  - update logic for event/order/config priority.
- The top holds the compare logic and the output register.

## Test plan
- Reset, cfg client 3 max=100, order 3 amt 60 then amt 40 -> both accept, exposure 100. Next order amt 1 -> reject, rsp_exposure 100.
- Client 5 max=10, three orders amt 20 -> rejects 1–3, state LOCKED. 4th order amt 1 -> reject, rsp_locked=1. cfg 5 max=10, order amt 1 -> accept.
- Exposure 50 on client 2, ex event amt 80 -> exposure 0, underflow=1. Same cycle: ex amt 30 + order amt 30 with max=50, exposure 50 -> accept, exposure 50.
- rsp_ready held 0 for 4 cycles with req_valid=1 -> req_ready=0 after the first handshake, rsp_* stable, exactly one decision per handshake once released.
- Order id 40 with N_CLIENTS=32 -> reject, no table change. ACC_W boundary: max=2^ACC_W-1, exposure=max-5, order amt 6 -> reject, no wrap.
- HRESETn pulsed while rsp_valid=1 -> rsp_valid 0, all exposures 0, next order rejected because max=0.
